// File: rtl/uart_access_sched_if.sv
// Bus bundle between the access scheduler, its fabric requesters/consumer and the CoreUART CPU port.
// The master modport is the scheduler's view; slave is the view of the surrounding logic.
interface uart_access_sched_if;
  logic       req0_valid;
  logic [7:0] req0_data;
  logic       req0_ready;
  logic       req1_valid;
  logic [7:0] req1_data;
  logic       req1_ready;

  logic       rx_valid;
  logic [7:0] rx_data;
  logic       rx_perr;
  logic       rx_ferr;
  logic       rx_ovf;
  logic       rx_ready;

  logic       uart_csn;
  logic       uart_wen;
  logic       uart_oen;
  logic [7:0] uart_data_in;
  logic       uart_txrdy;
  logic       uart_rxrdy;
  logic [7:0] uart_data_out;
  logic       uart_parity_err;
  logic       uart_framing_err;
  logic       uart_overflow;

  modport master (
    input  req0_valid, req0_data, req1_valid, req1_data, rx_ready,
    input  uart_txrdy, uart_rxrdy, uart_data_out,
    input  uart_parity_err, uart_framing_err, uart_overflow,
    output req0_ready, req1_ready,
    output rx_valid, rx_data, rx_perr, rx_ferr, rx_ovf,
    output uart_csn, uart_wen, uart_oen, uart_data_in
  );

  modport slave (
    output req0_valid, req0_data, req1_valid, req1_data, rx_ready,
    output uart_txrdy, uart_rxrdy, uart_data_out,
    output uart_parity_err, uart_framing_err, uart_overflow,
    input  req0_ready, req1_ready,
    input  rx_valid, rx_data, rx_perr, rx_ferr, rx_ovf,
    input  uart_csn, uart_wen, uart_oen, uart_data_in
  );
endinterface

// File: rtl/uart_access_sched.sv
// CoreUART CPU-port sequencer: round-robin transmit arbitration, autonomous rx drain into a
// one-entry buffer, and strobe widths / settle gaps so TXRDY/RXRDY are never sampled stale.
module uart_access_sched #(
  parameter int RD_HOLD = 2,  // cycles CSN/OEN low per read, 1..15
  parameter int SETTLE  = 2   // idle cycles after a strobe before status is trusted, 1..15
) (
  input logic                 CLK,
  input logic                 RESET,
  uart_access_sched_if.master bus
);

  typedef enum logic [1:0] {IDLE, WR, RD, GAP} state_t;

  localparam logic [3:0] RD_LOAD  = 4'(RD_HOLD - 1);
  localparam logic [3:0] GAP_LOAD = 4'(SETTLE - 1);

  state_t     state, state_nxt;
  logic [3:0] cnt, cnt_nxt;
  logic       last_grant;

  logic       rd_go, tx_ok, grant0, grant1, capture;

  logic       csn_q, wen_q, oen_q;
  logic [7:0] data_in_q;
  logic       rx_valid_q;
  logic [7:0] rx_data_q;
  logic       rx_perr_q, rx_ferr_q, rx_ovf_q;

  // Read beats write in IDLE; the buffer must be empty before a read is launched.
  assign rd_go   = (state == IDLE) && bus.uart_rxrdy && !rx_valid_q;
  assign tx_ok   = (state == IDLE) && !rd_go && bus.uart_txrdy && !RESET;
  assign grant0  = tx_ok && bus.req0_valid && (!bus.req1_valid || last_grant);
  assign grant1  = tx_ok && bus.req1_valid && (!bus.req0_valid || !last_grant);
  assign capture = (state == RD) && (cnt == 4'd0);

  always_comb begin
    // NOTE: every always_comb output gets a default first so no path leaves it unassigned,
    // which would otherwise infer a latch.
    state_nxt = state;
    cnt_nxt   = cnt;
    unique case (state)
      IDLE: begin
        if (rd_go) begin
          state_nxt = RD;
          cnt_nxt   = RD_LOAD;
        end else if (grant0 || grant1) begin
          state_nxt = WR;
        end
      end
      WR: begin
        state_nxt = GAP;
        cnt_nxt   = GAP_LOAD;
      end
      RD: begin
        if (cnt == 4'd0) begin
          state_nxt = GAP;
          cnt_nxt   = GAP_LOAD;
        end else begin
          cnt_nxt = cnt - 4'd1;
        end
      end
      GAP: begin
        if (cnt == 4'd0) state_nxt = IDLE;
        else             cnt_nxt   = cnt - 4'd1;
      end
      default: state_nxt = IDLE;
    endcase
  end

  // NOTE: sequential state uses non-blocking assignments so every register samples the
  // pre-edge values of its neighbours regardless of statement order.
  always_ff @(posedge CLK) begin
    if (RESET) begin
      state      <= IDLE;
      cnt        <= 4'd0;
      last_grant <= 1'b1;
      csn_q      <= 1'b1;
      wen_q      <= 1'b1;
      oen_q      <= 1'b1;
      data_in_q  <= 8'h00;
    end else begin
      state <= state_nxt;
      cnt   <= cnt_nxt;
      // Strobes come straight from flops decoded from the next state, so they cannot glitch.
      csn_q <= !((state_nxt == WR) || (state_nxt == RD));
      wen_q <= !(state_nxt == WR);
      oen_q <= !(state_nxt == RD);
      if (grant0) begin
        last_grant <= 1'b0;
        data_in_q  <= bus.req0_data;
      end else if (grant1) begin
        last_grant <= 1'b1;
        data_in_q  <= bus.req1_data;
      end
    end
  end

  // NOTE: the one-entry rx buffer is reset along with its valid bit so a reset visibly
  // discards the held byte and flags rather than leaving stale data on rx_data.
  always_ff @(posedge CLK) begin
    if (RESET) begin
      rx_valid_q <= 1'b0;
      rx_data_q  <= 8'h00;
      rx_perr_q  <= 1'b0;
      rx_ferr_q  <= 1'b0;
      rx_ovf_q   <= 1'b0;
    end else if (capture) begin
      rx_valid_q <= 1'b1;
      rx_data_q  <= bus.uart_data_out;
      rx_perr_q  <= bus.uart_parity_err;
      rx_ferr_q  <= bus.uart_framing_err;
      rx_ovf_q   <= bus.uart_overflow;
    end else if (rx_valid_q && bus.rx_ready) begin
      rx_valid_q <= 1'b0;
    end
  end

  assign bus.req0_ready   = grant0;
  assign bus.req1_ready   = grant1;
  assign bus.uart_csn     = csn_q;
  assign bus.uart_wen     = wen_q;
  assign bus.uart_oen     = oen_q;
  assign bus.uart_data_in = data_in_q;
  assign bus.rx_valid     = rx_valid_q;
  assign bus.rx_data      = rx_data_q;
  assign bus.rx_perr      = rx_perr_q;
  assign bus.rx_ferr      = rx_ferr_q;
  assign bus.rx_ovf       = rx_ovf_q;

endmodule

// File: tb/tb_uart_access_sched.sv
// Scoreboard bench for uart_access_sched: stimulus pushes expected grants, writes and rx bytes;
// a negedge monitor pops and compares them and polices strobe widths.
module tb_uart_access_sched;

  localparam int RD_HOLD = 2;
  localparam int SETTLE  = 2;

  typedef struct {
    logic [7:0] d;
    logic       p;
    logic       f;
    logic       o;
  } rx_t;

  logic clk = 1'b0;
  logic rst = 1'b1;

  uart_access_sched_if bus ();

  uart_access_sched #(.RD_HOLD(RD_HOLD), .SETTLE(SETTLE)) dut (
    .CLK   (clk),
    .RESET (rst),
    .bus   (bus)
  );

  always #5 clk = ~clk;

  int   errors = 0;
  int   checks = 0;
  int   oen_strobes = 0;
  int   exp_grant[$];
  logic [7:0] exp_wr[$];
  rx_t  exp_rx[$];

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got %0h expected %0h at %0t", name, act, exp, $time);
    end
  endtask

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  // Counts negedges until a ready pulse appears; 99 marks a timeout.
  task automatic wait_ready(input string name, input int exp_cycles);
    int  n = 0;
    bit  seen = 1'b0;
    while (n < 30 && !seen) begin
      @(negedge clk);
      n++;
      seen = bus.req0_ready || bus.req1_ready;
    end
    check(name, seen ? n : 99, exp_cycles);
  endtask

  task automatic wait_rx(input string name, input int exp_cycles);
    int  n = 0;
    bit  seen = 1'b0;
    while (n < 30 && !seen) begin
      @(negedge clk);
      n++;
      seen = bus.rx_valid;
    end
    check(name, seen ? n : 99, exp_cycles);
  endtask

  task automatic push_write(input int id, input logic [7:0] d);
    exp_grant.push_back(id);
    exp_wr.push_back(d);
  endtask

  task automatic push_rx(input logic [7:0] d, input logic p, input logic f, input logic o);
    rx_t r;
    r.d = d; r.p = p; r.f = f; r.o = o;
    exp_rx.push_back(r);
  endtask

  // Monitor: decoupled from stimulus, compares whatever the DUT presents.
  initial begin
    int   wen_run = 0;
    int   oen_run = 0;
    logic rx_prev = 1'b0;
    rx_t  r;
    forever begin
      @(negedge clk);
      if (bus.req0_ready || bus.req1_ready) begin
        check("one_ready", 32'(bus.req0_ready & bus.req1_ready), 0);
        if (exp_grant.size() == 0) check("grant_unexpected", 1, 0);
        else check("grant_id", 32'(bus.req1_ready), exp_grant.pop_front());
      end
      if (!bus.uart_wen) begin
        check("wr_csn", 32'(bus.uart_csn), 0);
        check("wr_oen", 32'(bus.uart_oen), 1);
        if (exp_wr.size() == 0) check("wr_unexpected", 1, 0);
        else check("wr_data", 32'(bus.uart_data_in), 32'(exp_wr.pop_front()));
        wen_run++;
      end else if (wen_run != 0) begin
        check("wen_width", wen_run, 1);
        wen_run = 0;
      end
      if (!bus.uart_oen) begin
        check("rd_csn", 32'(bus.uart_csn), 0);
        if (oen_run == 0) oen_strobes++;
        oen_run++;
      end else if (oen_run != 0) begin
        check("oen_width", oen_run, RD_HOLD);
        oen_run = 0;
      end
      if (bus.rx_valid && !rx_prev) begin
        if (exp_rx.size() == 0) check("rx_unexpected", 1, 0);
        else begin
          r = exp_rx.pop_front();
          check("rx_data", 32'(bus.rx_data), 32'(r.d));
          check("rx_flags", {29'd0, bus.rx_perr, bus.rx_ferr, bus.rx_ovf}, {29'd0, r.p, r.f, r.o});
        end
      end
      rx_prev = bus.rx_valid;
    end
  end

  initial begin
    #200000;
    $display("FAIL watchdog: simulation did not finish");
    $fatal(1, "watchdog");
  end

  initial begin
    int  snap;
    bit  seen;
    bus.req0_valid = 0; bus.req0_data = 0;
    bus.req1_valid = 0; bus.req1_data = 0;
    bus.rx_ready = 0;
    bus.uart_txrdy = 0; bus.uart_rxrdy = 0; bus.uart_data_out = 0;
    bus.uart_parity_err = 0; bus.uart_framing_err = 0; bus.uart_overflow = 0;

    // Reset state
    repeat (2) @(posedge clk);
    #1;
    check("rst_strobes", {29'd0, bus.uart_csn, bus.uart_wen, bus.uart_oen}, 7);
    check("rst_data_in", 32'(bus.uart_data_in), 0);
    check("rst_ready", {30'd0, bus.req0_ready, bus.req1_ready}, 0);
    check("rst_rx", {20'd0, bus.rx_valid, bus.rx_data, bus.rx_perr, bus.rx_ferr, bus.rx_ovf}, 0);
    rst = 0;

    // Single write, then period to the next accept of the same requester
    bus.uart_txrdy = 1;
    bus.req0_valid = 1; bus.req0_data = 8'hA5;
    push_write(0, 8'hA5);
    push_write(0, 8'hA5);
    wait_ready("wr_accept", 1);
    @(negedge clk);
    check("wr_wen_next", 32'(bus.uart_wen), 0);
    wait_ready("wr_period", 1 + SETTLE);
    tick();
    bus.req0_valid = 0;
    repeat (6) tick();

    // Contention after reset: req0 first, then alternating
    rst = 1; tick(); rst = 0;
    bus.req0_valid = 1; bus.req0_data = 8'h11;
    bus.req1_valid = 1; bus.req1_data = 8'h22;
    push_write(0, 8'h11); push_write(1, 8'h22);
    push_write(0, 8'h11); push_write(1, 8'h22);
    wait_ready("ct_g0", 1);
    wait_ready("ct_g1", 2 + SETTLE);
    wait_ready("ct_g2", 2 + SETTLE);
    wait_ready("ct_g3", 2 + SETTLE);
    tick();
    bus.req0_valid = 0; bus.req1_valid = 0;
    repeat (6) tick();

    // Read with parity error, then consumer clears
    bus.uart_rxrdy = 1; bus.uart_data_out = 8'h3C; bus.uart_parity_err = 1;
    push_rx(8'h3C, 1, 0, 0);
    wait_rx("rd_latency", RD_HOLD + 2);
    tick();
    bus.uart_rxrdy = 0; bus.uart_parity_err = 0; bus.rx_ready = 1;
    @(negedge clk);
    check("rd_valid_held", 32'(bus.rx_valid), 1);
    tick();
    bus.rx_ready = 0;
    @(negedge clk);
    check("rd_cleared", 32'(bus.rx_valid), 0);
    repeat (6) tick();

    // Backpressure: buffer full blocks reads, writes continue
    bus.uart_rxrdy = 1; bus.uart_data_out = 8'h5A; bus.uart_framing_err = 1;
    push_rx(8'h5A, 0, 1, 0);
    wait_rx("bp_rd", RD_HOLD + 2);
    snap = oen_strobes;
    tick();
    bus.uart_framing_err = 0;
    bus.req1_valid = 1; bus.req1_data = 8'h77;
    push_write(1, 8'h77);
    wait_ready("bp_wr", 2);
    tick();
    bus.req1_valid = 0;
    repeat (8) tick();
    check("bp_no_read", oen_strobes, snap);
    check("bp_held", 32'(bus.rx_valid), 1);

    // Clear, then read and write eligible in the same IDLE cycle: read first
    bus.rx_ready = 1;
    tick();
    bus.rx_ready = 0;
    bus.uart_data_out = 8'h6B;
    bus.req0_valid = 1; bus.req0_data = 8'h99;
    push_rx(8'h6B, 0, 0, 0);
    push_write(0, 8'h99);
    @(negedge clk);
    check("pri_no_ready", {30'd0, bus.req0_ready, bus.req1_ready}, 0);
    @(negedge clk);
    check("pri_read_first", 32'(bus.uart_oen), 0);
    wait_ready("pri_wr_after", RD_HOLD + SETTLE);
    tick();
    bus.req0_valid = 0; bus.uart_rxrdy = 0; bus.rx_ready = 1;
    tick();
    bus.rx_ready = 0;
    repeat (6) tick();

    // txrdy low holds off the write
    bus.uart_txrdy = 0;
    bus.req0_valid = 1; bus.req0_data = 8'hC3;
    seen = 0;
    repeat (6) begin
      @(negedge clk);
      if (bus.req0_ready || !bus.uart_wen || !bus.uart_csn) seen = 1;
    end
    check("txrdy_block", 32'(seen), 0);
    tick();
    bus.uart_txrdy = 1;
    push_write(0, 8'hC3);
    wait_ready("txrdy_go", 1);
    tick();
    bus.req0_valid = 0;
    repeat (6) tick();

    // Reset during the second OEN cycle, then contention restarts with req0
    bus.uart_rxrdy = 1; bus.uart_data_out = 8'hE7;
    @(posedge clk);
    @(posedge clk);
    #1;
    rst = 1;
    @(negedge clk);
    check("rst_in_rd", 32'(bus.uart_oen), 0);
    tick();
    check("rst_mid_strobes", {29'd0, bus.uart_csn, bus.uart_wen, bus.uart_oen}, 7);
    check("rst_mid_rx", 32'(bus.rx_valid), 0);
    rst = 0; bus.uart_rxrdy = 0;
    bus.req0_valid = 1; bus.req0_data = 8'hAA;
    bus.req1_valid = 1; bus.req1_data = 8'hBB;
    push_write(0, 8'hAA); push_write(1, 8'hBB);
    wait_ready("rst_g0", 1);
    wait_ready("rst_g1", 2 + SETTLE);
    tick();
    bus.req0_valid = 0; bus.req1_valid = 0;
    repeat (8) tick();

    check("queues_drained", exp_grant.size() + exp_wr.size() + exp_rx.size(), 0);
    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule
